// File: rtl/tx_control_module.sv
// -----------------------------------------------------------------------------
// tx_control_module
//
// Transmit-side controller for the serial link. Bytes from producers are
// queued in a small circular FIFO. A four-state FSM hands them one at a time
// to the UART transmit core.
//
// Handshake (the only flow-control contract of this block):
//   - Producer side: Wr_Sig is a one-cycle strobe with no ready. A write is
//     accepted when Full_Sig is low at the sampling edge. A write while full is
//     dropped and sets the sticky Overflow_Sig.
//   - TX core side: TX_En_Sig acts as "valid". It is held high with TX_Data
//     stable until the core returns a one-cycle TX_Done_Sig. TX_Done_Sig acts
//     as "ready+complete". TX_En_Sig then drops for at least one cycle (GAP) so
//     the core re-arms before the next byte.
//
// Ports:
//   CLK           system clock, rising edge
//   RSTn          asynchronous active-low reset
//   Wr_Sig        write strobe
//   Wr_Data       byte to queue
//   TX_Done_Sig   end-of-byte pulse from the TX core
//   TX_En_Sig     registered enable to the TX core
//   TX_Data       registered byte to the TX core
//   Full_Sig      FIFO occupancy == depth
//   Empty_Sig     FIFO occupancy == 0
//   Count         FIFO occupancy
//   Overflow_Sig  sticky dropped-write flag
//   State_Dbg     current FSM state (0 IDLE, 1 LOAD, 2 SEND, 3 GAP)
// -----------------------------------------------------------------------------
module tx_control_module #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Wr_Sig,
  input  logic [7:0]            Wr_Data,
  input  logic                  TX_Done_Sig,
  output logic                  TX_En_Sig,
  output logic [7:0]            TX_Data,
  output logic                  Full_Sig,
  output logic                  Empty_Sig,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow_Sig,
  output logic [1:0]            State_Dbg
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    tx_en_q, tx_en_d;
  logic [7:0]              tx_data_q, tx_data_d;

  logic                    wr_fire;
  logic                    pop;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign Full_Sig  = (count_q == DEPTH_CNT);
  assign Empty_Sig = (count_q == '0);

  // The full check uses the pre-edge count. A write while full is dropped
  // even if a pop happens on the same edge.
  assign wr_fire = Wr_Sig && !Full_Sig;
  // LOAD is only entered with a non-empty FIFO, and only LOAD pops. So a pop
  // never underflows.
  assign pop     = (state_q == S_LOAD);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (Wr_Sig && Full_Sig) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (wr_fire && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_fire && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage is not reset. Stale entries are never read because the count
  // gates every read.
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= Wr_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = mem_q[rd_ptr_q];
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (TX_Done_Sig) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Enable is registered from the next state, so it is high exactly while
    // the FSM sits in SEND.
    tx_en_d = (state_d == S_SEND);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign TX_En_Sig    = tx_en_q;
  assign TX_Data      = tx_data_q;
  assign Count        = count_q;
  assign Overflow_Sig = ovf_q;
  assign State_Dbg    = state_q;

  // ---------------------------------------------------------------------------
  // Embedded checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_data_stable: assert property (@(posedge CLK) disable iff (!RSTn)
    (TX_En_Sig && $past(TX_En_Sig)) |-> $stable(TX_Data));

  a_count_bound: assert property (@(posedge CLK) disable iff (!RSTn)
    count_q <= DEPTH_CNT);

  a_no_empty_pop: assert property (@(posedge CLK) disable iff (!RSTn)
    (state_q == S_LOAD) |-> (count_q != '0));
`endif

endmodule

// File: tb/tb_tx_control_module.sv
// -----------------------------------------------------------------------------
// tb_tx_control_module
//
// Directed bench for tx_control_module (DEPTH_LOG2 = 3). The bench has these
// parts:
//   - a reset phase
//   - a table of per-cycle vectors for the fill/overflow sequence
//   - a TX-core model task that serves bytes against an expected queue
//   - hand-written sequences for latency, burst, write-during-LOAD, spurious
//     done and mid-transmission reset
// -----------------------------------------------------------------------------
module tb_tx_control_module;

  localparam int DL = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          Wr_Sig = 1'b0;
  logic [7:0]    Wr_Data = 8'd0;
  logic          TX_Done_Sig = 1'b0;
  logic          TX_En_Sig;
  logic [7:0]    TX_Data;
  logic          Full_Sig;
  logic          Empty_Sig;
  logic [DL:0]   Count;
  logic          Overflow_Sig;
  logic [1:0]    State_Dbg;

  always #5 CLK = ~CLK;

  tx_control_module #(.DEPTH_LOG2(DL)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Wr_Sig       (Wr_Sig),
    .Wr_Data      (Wr_Data),
    .TX_Done_Sig  (TX_Done_Sig),
    .TX_En_Sig    (TX_En_Sig),
    .TX_Data      (TX_Data),
    .Full_Sig     (Full_Sig),
    .Empty_Sig    (Empty_Sig),
    .Count        (Count),
    .Overflow_Sig (Overflow_Sig),
    .State_Dbg    (State_Dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  int          peak = 0;
  bit          mon_on = 1'b0;

  always @(negedge CLK) begin
    if (mon_on && int'(Count) > peak) peak = int'(Count);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset(input string tag);
    RSTn = 1'b0;
    TX_Done_Sig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      Wr_Sig  = ~Wr_Sig;
      Wr_Data = 8'($urandom_range(0, 255));
    end
    Wr_Sig = 1'b0;
    check({tag, "_en"},    32'(TX_En_Sig), 0);
    check({tag, "_data"},  32'(TX_Data), 0);
    check({tag, "_count"}, 32'(Count), 0);
    check({tag, "_empty"}, 32'(Empty_Sig), 1);
    check({tag, "_full"},  32'(Full_Sig), 0);
    check({tag, "_ovf"},   32'(Overflow_Sig), 0);
    @(negedge CLK);
    RSTn = 1'b1;
    step();
  endtask

  task automatic write_byte(input logic [7:0] d);
    Wr_Sig  = 1'b1;
    Wr_Data = d;
    step();
    Wr_Sig  = 1'b0;
  endtask

  task automatic pulse_done();
    TX_Done_Sig = 1'b1;
    step();
    TX_Done_Sig = 1'b0;
  endtask

  // TX-core model: serves n bytes and holds each one for `hold` cycles. Each
  // byte is compared with the front of exp_q. When chk_gap is set, the number
  // of low cycles between consecutive enables is also checked.
  task automatic serve(input int n, input int hold, input bit chk_gap);
    int         low;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      low = 0;
      while (!TX_En_Sig && low < 60) begin
        step();
        low++;
      end
      if (!TX_En_Sig) begin
        n_tests++;
        n_fail++;
        $display("FAIL serve_timeout: byte %0d never enabled", k);
        return;
      end
      if (chk_gap && k > 0) check($sformatf("gap_%0d", k), 32'(low), 3);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL serve_extra: got %0h expected none", TX_Data);
        return;
      end
      d = exp_q.pop_front();
      check($sformatf("byte_%0d", k), 32'(TX_Data), 32'(d));
      repeat (hold) step();
      check($sformatf("hold_en_%0d", k), 32'(TX_En_Sig), 1);
      check($sformatf("hold_data_%0d", k), 32'(TX_Data), 32'(d));
      pulse_done();
      check($sformatf("done_en_%0d", k), 32'(TX_En_Sig), 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: fill to full, overflow, then the first pop after done.
  // Each row is applied for one edge and checked #1 after that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [7:0]  din;
    logic        done;
    logic        en;
    logic [7:0]  dout;
    logic [DL:0] cnt;
    logic        full;
    logic        empty;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    din    done  en    dout   cnt    full  empty ovf
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h06, 1'b0, 1'b1, 8'h01, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h08, 1'b0, 1'b1, 8'h01, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h09, 1'b0, 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 4'd7, 1'b0, 1'b0, 1'b1};

    // ---- reset ---------------------------------------------------------------
    do_reset("rst1");

    // ---- overflow table ------------------------------------------------------
    for (int i = 0; i < 14; i++) begin
      Wr_Sig      = vecs[i].wr;
      Wr_Data     = vecs[i].din;
      TX_Done_Sig = vecs[i].done;
      step();
      Wr_Sig      = 1'b0;
      TX_Done_Sig = 1'b0;
      check($sformatf("v%0d_en", i),    32'(TX_En_Sig),    32'(vecs[i].en));
      check($sformatf("v%0d_data", i),  32'(TX_Data),      32'(vecs[i].dout));
      check($sformatf("v%0d_count", i), 32'(Count),        32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i),  32'(Full_Sig),     32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(Empty_Sig),    32'(vecs[i].empty));
      check($sformatf("v%0d_ovf", i),   32'(Overflow_Sig), 32'(vecs[i].ovf));
    end
    // Drain what remains: 02 is in SEND, then 03..09. 0A was dropped.
    exp_q.delete();
    for (int b = 2; b <= 9; b++) exp_q.push_back(8'(b));
    serve(8, 4, 1'b1);
    repeat (3) step();
    check("ovf_drain_empty", 32'(Empty_Sig), 1);
    check("ovf_drain_sticky", 32'(Overflow_Sig), 1);
    check("ovf_drain_q", 32'(exp_q.size()), 0);

    // ---- reset clears the sticky flag and TX_Data ----------------------------
    do_reset("rst2");

    // ---- single byte: latency of two edges -----------------------------------
    write_byte(8'h55);
    check("single_e0_en", 32'(TX_En_Sig), 0);
    check("single_e0_cnt", 32'(Count), 1);
    check("single_e0_empty", 32'(Empty_Sig), 0);
    step();
    check("single_e1_en", 32'(TX_En_Sig), 0);
    step();
    check("single_e2_en", 32'(TX_En_Sig), 1);
    check("single_e2_data", 32'(TX_Data), 32'h55);
    check("single_e2_cnt", 32'(Count), 0);
    repeat (10) step();
    check("single_wait_en", 32'(TX_En_Sig), 1);
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_after_en_%0d", i), 32'(TX_En_Sig), 0);
      step();
    end
    check("single_empty", 32'(Empty_Sig), 1);
    check("single_data_hold", 32'(TX_Data), 32'h55);

    // ---- burst of eight against a slow TX core -------------------------------
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hA0 + i));
    peak   = 0;
    mon_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          Wr_Sig  = 1'b1;
          Wr_Data = 8'(8'hA0 + i);
          step();
        end
        Wr_Sig = 1'b0;
      end
      serve(8, 20, 1'b1);
    join
    mon_on = 1'b0;
    check("burst_peak", 32'(peak), 7);
    check("burst_ovf", 32'(Overflow_Sig), 0);
    check("burst_q", 32'(exp_q.size()), 0);
    repeat (2) step();
    check("burst_empty", 32'(Empty_Sig), 1);

    // ---- write during LOAD with Count = 3 ------------------------------------
    write_byte(8'hB0);
    step();
    step();
    check("sim_b0_en", 32'(TX_En_Sig), 1);
    check("sim_b0_data", 32'(TX_Data), 32'hB0);
    write_byte(8'hB1);
    write_byte(8'hB2);
    write_byte(8'hB3);
    check("sim_pre_cnt", 32'(Count), 3);
    pulse_done();
    begin
      int guard = 0;
      while (State_Dbg != 2'd1 && guard < 10) begin
        step();
        guard++;
      end
      check("sim_reach_load", 32'(State_Dbg), 1);
    end
    check("sim_load_cnt", 32'(Count), 3);
    write_byte(8'hB4);
    check("sim_post_cnt", 32'(Count), 3);
    check("sim_post_en", 32'(TX_En_Sig), 1);
    check("sim_post_data", 32'(TX_Data), 32'hB1);
    exp_q.delete();
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hB3);
    exp_q.push_back(8'hB4);
    serve(4, 3, 1'b1);
    check("sim_q", 32'(exp_q.size()), 0);

    // ---- spurious done while idle and empty ----------------------------------
    repeat (3) step();
    check("spur_pre_state", 32'(State_Dbg), 0);
    pulse_done();
    check("spur_state", 32'(State_Dbg), 0);
    check("spur_en", 32'(TX_En_Sig), 0);
    check("spur_cnt", 32'(Count), 0);
    step();
    check("spur_state2", 32'(State_Dbg), 0);
    check("spur_data", 32'(TX_Data), 32'hB4);

    // ---- reset in the middle of SEND -----------------------------------------
    write_byte(8'hC0);
    write_byte(8'hC1);
    write_byte(8'hC2);
    check("mid_en", 32'(TX_En_Sig), 1);
    check("mid_data", 32'(TX_Data), 32'hC0);
    check("mid_cnt", 32'(Count), 2);
    #3;
    RSTn = 1'b0;
    #1;
    check("mid_rst_en", 32'(TX_En_Sig), 0);
    check("mid_rst_cnt", 32'(Count), 0);
    check("mid_rst_empty", 32'(Empty_Sig), 1);
    check("mid_rst_data", 32'(TX_Data), 0);
    repeat (2) step();
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst_state_%0d", i), 32'(State_Dbg), 0);
      check($sformatf("post_rst_en_%0d", i), 32'(TX_En_Sig), 0);
    end
    write_byte(8'hD0);
    step();
    step();
    check("post_rst_new_en", 32'(TX_En_Sig), 1);
    check("post_rst_new_data", 32'(TX_Data), 32'hD0);
    pulse_done();
    check("post_rst_done_en", 32'(TX_En_Sig), 0);

    // ---- report --------------------------------------------------------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
